// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, control states and
// the result-width helper.
package alu_pkg;

   localparam logic [4:0] ALU_OP_OR   = 5'd0;
   localparam logic [4:0] ALU_OP_AND  = 5'd1;
   localparam logic [4:0] ALU_OP_NEG  = 5'd2;
   localparam logic [4:0] ALU_OP_NOT  = 5'd3;
   localparam logic [4:0] ALU_OP_ROL  = 5'd4;
   localparam logic [4:0] ALU_OP_ROR  = 5'd5;
   localparam logic [4:0] ALU_OP_SHL  = 5'd6;
   localparam logic [4:0] ALU_OP_SHRA = 5'd7;
   localparam logic [4:0] ALU_OP_SHR  = 5'd8;
   localparam logic [4:0] ALU_OP_ADD  = 5'd9;
   localparam logic [4:0] ALU_OP_SUB  = 5'd10;
   localparam logic [4:0] ALU_OP_ADDU = 5'd11;
   localparam logic [4:0] ALU_OP_MUL  = 5'd12;
   localparam logic [4:0] ALU_OP_DIV  = 5'd13;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN_MUL = 2'd1,
      RUN_DIV = 2'd2,
      FIX_DIV = 2'd3
   } state_t;

   function automatic int result_w(input int data_width);
      return 2 * data_width;
   endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the control unit and alu_multicycle.
// ALU_DIV0_FLAG_EN adds the div_by_zero status line.
interface alu_multicycle_if
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
);
   logic                            start;
   logic [4:0]                      op;
   logic [DATA_WIDTH-1:0]           A;
   logic [DATA_WIDTH-1:0]           B;
   logic                            busy;
   logic                            done;
   logic [result_w(DATA_WIDTH)-1:0] result;
`ifdef ALU_DIV0_FLAG_EN
   logic                            div_by_zero;

   modport master (output start, op, A, B, input busy, done, result, div_by_zero);
   modport slave  (input start, op, A, B, output busy, done, result, div_by_zero);
`else
   modport master (output start, op, A, B, input busy, done, result);
   modport slave  (input start, op, A, B, output busy, done, result);
`endif
endinterface

// File: rtl/seq_restoring_div.sv
// Unsigned restoring divider datapath: one quotient bit per step, operands
// loaded as magnitudes; sign handling lives in the caller.
module seq_restoring_div #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  load,
   input  logic                  step,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder
);
   localparam int W = DATA_WIDTH;

   logic [W-1:0] rem;
   logic [W-1:0] quo;
   logic [W-1:0] dvs;
   logic [W:0]   r_sh;
   logic [W:0]   diff;

   // The dividend shifts out of quo from the top while quotient bits enter at the bottom.
   always_comb begin
      r_sh = {rem, quo[W-1]};
      diff = r_sh - {1'b0, dvs};
   end

   always_ff @(posedge clock) begin
      if (load) begin
         rem <= '0;
         quo <= dividend;
         dvs <= divisor;
      end else if (step) begin
         if (diff[W]) begin
            rem <= r_sh[W-1:0];
            quo <= {quo[W-2:0], 1'b0};
         end else begin
            rem <= diff[W-1:0];
            quo <= {quo[W-2:0], 1'b1};
         end
      end
   end

   assign quotient  = quo;
   assign remainder = rem;
endmodule

// File: rtl/alu_multicycle.sv
// Clocked ALU: registered single-cycle ops, iterative Booth MUL and restoring DIV
// behind a start/busy/done handshake. ALU_DIV0_FLAG_EN adds the div_by_zero flag.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input logic              clock,
   input logic              reset,
   alu_multicycle_if.slave  bus
);
   localparam int W  = DATA_WIDTH;
   localparam int RW = result_w(DATA_WIDTH);
   localparam logic [SHAMT_W:0] LAST = (SHAMT_W+1)'(DATA_WIDTH - 1);

   state_t            state;
   state_t            state_next;
   logic [SHAMT_W:0]  cnt;
   logic              accept;
   logic              single_done;
   logic              mul_last;
   logic              div_last;
   logic              div_load;
   logic              busy_c;

   logic [W-1:0]      a_reg;
   logic              sign_a;
   logic              sign_b;
   logic              b_zero;
   logic [RW-1:0]     result_r;
   logic              done_r;

   logic signed [W:0] m;
   logic signed [W:0] acc;
   logic [W-1:0]      q;
   logic              q_m1;
   logic signed [W:0] acc_sum;
   logic signed [W:0] acc_next;
   logic [W-1:0]      q_next;
   logic              q_m1_next;

   logic [W-1:0]      abs_a;
   logic [W-1:0]      abs_b;
   logic [W-1:0]      div_quo;
   logic [W-1:0]      div_rem;

   function automatic logic [RW-1:0] alu_single(input logic [4:0] f_op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic [SHAMT_W-1:0] amt;
      logic signed [W-1:0] sa;
      logic [W-1:0]        sra;
      logic [RW-1:0]       r;
      amt = b[SHAMT_W-1:0];
      sa  = a;
      sra = sa >>> amt;
      r   = '0;
      case (f_op)
         ALU_OP_OR:   r = {{W{1'b0}}, a | b};
         ALU_OP_AND:  r = {{W{1'b0}}, a & b};
         ALU_OP_NEG:  r = '0 - {{W{a[W-1]}}, a};
         ALU_OP_NOT:  r = {{W{1'b0}}, ~a};
         ALU_OP_ROL:  r = {{W{1'b0}}, (a << amt) | (a >> (W - int'(amt)))};
         ALU_OP_ROR:  r = {{W{1'b0}}, (a >> amt) | (a << (W - int'(amt)))};
         ALU_OP_SHL:  r = {{W{1'b0}}, a << amt};
         ALU_OP_SHRA: r = {{W{1'b0}}, sra};
         ALU_OP_SHR:  r = {{W{1'b0}}, a >> amt};
         ALU_OP_ADD:  r = {{W{a[W-1]}}, a} + {{W{b[W-1]}}, b};
         ALU_OP_SUB:  r = {{W{a[W-1]}}, a} - {{W{b[W-1]}}, b};
         ALU_OP_ADDU: r = {{W{1'b0}}, a} + {{W{1'b0}}, b};
         default:     r = '0;
      endcase
      return r;
   endfunction

   // Quotient truncates toward zero, remainder follows the dividend's sign.
   function automatic logic [RW-1:0] div_fix(input logic [W-1:0] quo,
                                             input logic [W-1:0] rem,
                                             input logic         sa,
                                             input logic         sb,
                                             input logic         bz,
                                             input logic [W-1:0] a);
      logic [W-1:0] qs;
      logic [W-1:0] rs;
      qs = (sa ^ sb) ? -quo : quo;
      rs = sa ? -rem : rem;
      return bz ? {a, {W{1'b1}}} : {rs, qs};
   endfunction

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.start && bus.op == ALU_OP_MUL)      state_next = RUN_MUL;
            else if (bus.start && bus.op == ALU_OP_DIV) state_next = RUN_DIV;
         end
         RUN_MUL: if (cnt == LAST) state_next = IDLE;
         RUN_DIV: if (cnt == LAST) state_next = FIX_DIV;
         FIX_DIV: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control outputs
   always_comb begin
      busy_c      = (state != IDLE);
      accept      = (state == IDLE) && bus.start;
      single_done = accept && bus.op != ALU_OP_MUL && bus.op != ALU_OP_DIV;
      div_load    = accept && bus.op == ALU_OP_DIV;
      mul_last    = (state == RUN_MUL) && (cnt == LAST);
      div_last    = (state == FIX_DIV);
   end

   // Booth step: examine {q[0], q_m1}, add/sub multiplicand, shift the pair right.
   always_comb begin
      case ({q[0], q_m1})
         2'b01:   acc_sum = acc + m;
         2'b10:   acc_sum = acc - m;
         default: acc_sum = acc;
      endcase
      {acc_next, q_next, q_m1_next} = {acc_sum[W], acc_sum, q};
   end

   assign abs_a = bus.A[W-1] ? (~bus.A + 1'b1) : bus.A;
   assign abs_b = bus.B[W-1] ? (~bus.B + 1'b1) : bus.B;

   seq_restoring_div #(.DATA_WIDTH(W)) u_div (
      .clock     (clock),
      .load      (div_load),
      .step      (state == RUN_DIV),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // Operand capture and multiplier iteration
   always_ff @(posedge clock) begin
      if (accept) begin
         a_reg  <= bus.A;
         m      <= {bus.A[W-1], bus.A};
         acc    <= '0;
         q      <= bus.B;
         q_m1   <= 1'b0;
         sign_a <= bus.A[W-1];
         sign_b <= bus.B[W-1];
         b_zero <= (bus.B == '0);
      end else if (state == RUN_MUL) begin
         acc  <= acc_next;
         q    <= q_next;
         q_m1 <= q_m1_next;
      end
   end

   // Completion: counter, result and done pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt      <= '0;
         done_r   <= 1'b0;
         result_r <= '0;
      end else begin
         done_r <= 1'b0;
         if (accept) begin
            cnt <= '0;
            if (single_done) begin
               result_r <= alu_single(bus.op, bus.A, bus.B);
               done_r   <= 1'b1;
            end
         end else if (busy_c) begin
            cnt <= cnt + 1'b1;
            if (mul_last) begin
               result_r <= {acc_next[W-1:0], q_next};
               done_r   <= 1'b1;
            end else if (div_last) begin
               result_r <= div_fix(div_quo, div_rem, sign_a, sign_b, b_zero, a_reg);
               done_r   <= 1'b1;
            end
         end
      end
   end

`ifdef ALU_DIV0_FLAG_EN
   logic dbz;

   always_ff @(posedge clock) begin
      if (reset)                       dbz <= 1'b0;
      else if (div_last)               dbz <= b_zero;
      else if (single_done || mul_last) dbz <= 1'b0;
   end

   assign bus.div_by_zero = dbz;
`endif

   assign bus.busy   = busy_c;
   assign bus.done   = done_r;
   assign bus.result = result_r;
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (DATA_WIDTH=32) against an arithmetic
// reference model; checks div_by_zero too when ALU_DIV0_FLAG_EN is defined.
module tb_alu_multicycle;
   localparam int W = 32;

   logic clock = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   alu_multicycle_if #(.DATA_WIDTH(W)) bus ();

   alu_multicycle #(.DATA_WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [63:0] model(input logic [4:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      qt;
      longint      rm;
      logic [63:0] qv;
      logic [63:0] rv;
      logic [31:0] x;
      int          amt;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      amt = int'(b[4:0]);
      x   = a;
      case (op)
         5'd0:  return {32'd0, a | b};
         5'd1:  return {32'd0, a & b};
         5'd2:  return 64'(-sa);
         5'd3:  return {32'd0, ~a};
         5'd4:  begin for (int i = 0; i < amt; i++) x = {x[30:0], x[31]}; return {32'd0, x}; end
         5'd5:  begin for (int i = 0; i < amt; i++) x = {x[0], x[31:1]}; return {32'd0, x}; end
         5'd6:  return {32'd0, a << amt};
         5'd7:  begin x = 32'(sa >>> amt); return {32'd0, x}; end
         5'd8:  return {32'd0, a >> amt};
         5'd9:  return 64'(sa + sb);
         5'd10: return 64'(sa - sb);
         5'd11: return {32'd0, a} + {32'd0, b};
         5'd12: return 64'(sa * sb);
         5'd13: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            qt = sa / sb;
            rm = sa % sb;
            qv = 64'(qt);
            rv = 64'(rm);
            return {rv[31:0], qv[31:0]};
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic int latency(input logic [4:0] op);
      if (op == 5'd12) return 32;
      if (op == 5'd13) return 33;
      return 0;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0: return 32'h8000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'hFFFF_FFFF;
         3: return 32'd0;
         4: return 32'(1 + $urandom_range(0, 30));
         default: return $urandom;
      endcase
   endfunction

   // Drive a request, let edge k capture it, then scramble the inputs.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.A     = a;
      bus.B     = b;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.op    = 5'($urandom);
      bus.A     = $urandom;
      bus.B     = $urandom;
   endtask

   // Count cycles after the capture edge until done; optionally inject a stray start.
   task automatic wait_done(input int inject_at, output int lat, output int busy_n, output logic seen);
      lat    = 0;
      busy_n = 0;
      seen   = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.busy === 1'b1) busy_n++;
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            lat  = i;
            break;
         end
         if (i == inject_at) begin
            bus.start = 1'b1;
            bus.op    = 5'd12;
            bus.A     = 32'd5;
            bus.B     = 32'd5;
         end
         @(posedge clock);
         #1;
         bus.start = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (2) @(posedge clock);
      #1;
      tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 64'd0) begin
         fails++;
         $display("FAIL reset_state: busy=%b done=%b result=%h, want 0 0 0", bus.busy, bus.done, bus.result);
      end
`ifdef ALU_DIV0_FLAG_EN
      tests++;
      if (bus.div_by_zero !== 1'b0) begin
         fails++;
         $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_single_cycle();
      logic [4:0]  ops [7]  = '{5'd9, 5'd11, 5'd4, 5'd7, 5'd2, 5'd10, 5'd20};
      logic [31:0] as  [7]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0000,
                                32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
      logic [31:0] bs  [7]  = '{32'd1, 32'd1, 32'd4, 32'd31, 32'd0, 32'd1, 32'h1111_1111};
      logic [63:0] exp [7]  = '{64'h0000_0000_8000_0000, 64'h0000_0001_0000_0000,
                                64'h0000_0000_0000_0018, 64'h0000_0000_FFFF_FFFF,
                                64'h0000_0000_8000_0000, 64'hFFFF_FFFF_7FFF_FFFF,
                                64'h0000_0000_0000_0000};
      int   lat;
      int   bn;
      logic seen;
      for (int i = 0; i < 7; i++) begin
         issue(ops[i], as[i], bs[i]);
         wait_done(-1, lat, bn, seen);
         tests++;
         if (!seen || lat != 0 || bn != 0) begin
            fails++;
            $display("FAIL single_latency op=%0d: seen=%b lat=%0d busy=%0d want lat 0 busy 0", ops[i], seen, lat, bn);
         end
         tests++;
         if (bus.result !== exp[i]) begin
            fails++;
            $display("FAIL single_result op=%0d: got %h want %h", ops[i], bus.result, exp[i]);
         end
      end
   endtask

   task automatic test_mul();
      int   lat;
      int   bn;
      logic seen;
      issue(5'd12, 32'hFFFF_FFFD, 32'd7);
      wait_done(10, lat, bn, seen);
      tests++;
      if (!seen || lat != 32 || bn != 32) begin
         fails++;
         $display("FAIL mul_latency: seen=%b lat=%0d busy_cycles=%0d want 32 32", seen, lat, bn);
      end
      tests++;
      if (bus.result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         fails++;
         $display("FAIL mul_result: got %h want ffffffffffffffeb", bus.result);
      end
      @(posedge clock);
      #1;
      tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         fails++;
         $display("FAIL mul_hold: done=%b busy=%b result=%h want 0 0 ffffffffffffffeb", bus.done, bus.busy, bus.result);
      end
   endtask

   task automatic test_back_to_back();
      int          lat;
      int          bn;
      logic        seen;
      logic [63:0] want;
      issue(5'd13, 32'hFFFF_FFF9, 32'd2);
      wait_done(-1, lat, bn, seen);
      tests++;
      if (!seen || lat != 33 || bn != 33) begin
         fails++;
         $display("FAIL div_latency: seen=%b lat=%0d busy_cycles=%0d want 33 33", seen, lat, bn);
      end
      tests++;
      if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         fails++;
         $display("FAIL div_result: got %h want fffffffffffffffd", bus.result);
      end
      // Start during the done cycle must be accepted.
      issue(5'd9, 32'd3, 32'd4);
      tests++;
      if (bus.done !== 1'b1 || bus.result !== 64'd7) begin
         fails++;
         $display("FAIL b2b_add: done=%b result=%h want 1 7", bus.done, bus.result);
      end
      issue(5'd13, 32'd100, 32'hFFFF_FFF9);
      wait_done(-1, lat, bn, seen);
      want = model(5'd13, 32'd100, 32'hFFFF_FFF9);
      tests++;
      if (!seen || lat != 33 || bus.result !== want) begin
         fails++;
         $display("FAIL b2b_div: seen=%b lat=%0d result=%h want lat 33 result %h", seen, lat, bus.result, want);
      end
   endtask

   task automatic test_div0();
      int   lat;
      int   bn;
      logic seen;
      issue(5'd13, 32'd5, 32'd0);
      wait_done(-1, lat, bn, seen);
      tests++;
      if (!seen || lat != 33 || bus.result !== 64'h0000_0005_FFFF_FFFF) begin
         fails++;
         $display("FAIL div0_result: seen=%b lat=%0d result=%h want lat 33 result 00000005ffffffff", seen, lat, bus.result);
      end
`ifdef ALU_DIV0_FLAG_EN
      tests++;
      if (bus.div_by_zero !== 1'b1) begin
         fails++;
         $display("FAIL div0_flag_set: got %b want 1", bus.div_by_zero);
      end
      repeat (3) @(posedge clock);
      #1;
      tests++;
      if (bus.div_by_zero !== 1'b1) begin
         fails++;
         $display("FAIL div0_flag_hold: got %b want 1", bus.div_by_zero);
      end
      issue(5'd0, 32'd1, 32'd2);
      tests++;
      if (bus.div_by_zero !== 1'b0) begin
         fails++;
         $display("FAIL div0_flag_clear: got %b want 0", bus.div_by_zero);
      end
`endif
   endtask

   task automatic test_random();
      int          lat;
      int          bn;
      logic        seen;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] want;
      for (int n = 0; n < 48; n++) begin
         op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(14, 31)) : 5'($urandom_range(0, 13));
         a  = pick_operand();
         b  = pick_operand();
         want = model(op, a, b);
         issue(op, a, b);
         wait_done(-1, lat, bn, seen);
         tests++;
         if (!seen || lat != latency(op) || bus.result !== want) begin
            fails++;
            $display("FAIL random op=%0d a=%h b=%h: seen=%b lat=%0d result=%h want lat %0d result %h",
                     op, a, b, seen, lat, bus.result, latency(op), want);
         end
`ifdef ALU_DIV0_FLAG_EN
         tests++;
         if (bus.div_by_zero !== (op == 5'd13 && b == 32'd0)) begin
            fails++;
            $display("FAIL random_dbz op=%0d b=%h: got %b", op, b, bus.div_by_zero);
         end
`endif
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic test_reset_abort();
      logic seen;
      issue(5'd12, 32'h0001_0003, 32'h0000_0077);
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 64'd0) begin
         fails++;
         $display("FAIL abort_state: busy=%b done=%b result=%h want 0 0 0", bus.busy, bus.done, bus.result);
      end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
      end
      tests++;
      if (seen !== 1'b0 || bus.result !== 64'd0) begin
         fails++;
         $display("FAIL abort_no_done: activity=%b result=%h want 0 0", seen, bus.result);
      end
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_mul();
      test_back_to_back();
      test_div0();
      test_random();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
